fault_injector: RTL and testbench
=================================

Name: fault_injector

Overview:
Parametrised, stream-based error injector for the SEC-DED datapath. It sits between the encoder and the decoder under test and carries codewords (data plus check bits) over a valid/ready stream through one register stage. Per word, it optionally flips bits according to a configured mode: single, double, periodic or LFSR-random.

Parameters:
DATA_W, 8, data bits per word; must be 4..64.
CHECK_W, derived (5 for DATA_W=8), Hamming check bits plus one overall-parity bit; computed by a package function, not overridable.
CW_W, derived (DATA_W+CHECK_W = 13), codeword positions.
IDX_W, derived ($clog2(CW_W)), position index width.
LFSR_SEED, 16'hACE1, reset seed of the random-mode LFSR; must be nonzero.

Ports:
clk  in  1  clock
rst_n  in  1  reset
cfg_mode  in  3  0=OFF 1=SINGLE 2=DOUBLE 3=PERIODIC 4=RANDOM 5=BURST (FI_BURST_EN only); 6,7 = OFF
cfg_idx_a  in  IDX_W  primary flip position
cfg_idx_b  in  IDX_W  second flip position (DOUBLE)
cfg_period  in  16  words per injection (PERIODIC/RANDOM); 0 is treated as 1
cfg_arm  in  1  one-cycle pulse; latches all cfg_* into shadow registers
in_valid / in_ready  in / out  1  input handshake
in_data  in  DATA_W  input data
in_check  in  CHECK_W  input check bits
out_valid / out_ready  out / in  1  output handshake
out_data  out  DATA_W  output data
out_check  out  CHECK_W  output check bits
out_injected  out  1  current out word was modified
inj_count  out  16  words injected since reset; saturates at 16'hFFFF
err_bad_idx  out  1  sticky; a shadow index was >= CW_W when used
busy  out  1  state is ARMED or RUN

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE; shadow registers 0; period counter 0; LFSR = LFSR_SEED.
  - Reset mid-transfer drops the held word.
- Position map, index -> bit:
  - 0 -> check[CHECK_W-1] (overall parity).
  - Power-of-two index 2^k -> check[k].
  - Every other index -> data bits in ascending order. For DATA_W=8: 3,5,6,7,9,10,11,12 -> data[0..7].
  - Index >= CW_W flips nothing.
- Handshake and latency:
  - in_ready = !out_valid || out_ready.
  - A transfer (in_valid && in_ready) loads the output register next edge. Latency is 1 cycle; full throughput is 1 word/cycle.
  - Output fields stay stable while out_valid && !out_ready.
  - Word order and count are preserved; no words are dropped or created.
- State machine (transitions on accepted words unless noted):
  - IDLE: pass-through.
  - cfg_arm, any state: latch shadow registers and clear the period counter. Next state: OFF -> IDLE; SINGLE/DOUBLE/BURST -> ARMED; PERIODIC/RANDOM -> RUN.
  - ARMED: the next accepted word is flipped (SINGLE: idx_a; DOUBLE: idx_a and idx_b), then -> DONE.
  - RUN: counter increments per word. When counter == period-1, the word is flipped and the counter clears. PERIODIC flips idx_a. RANDOM flips an LFSR-derived index.
  - DONE: pass-through until the next cfg_arm.
- Random mode:
  - LFSR is 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, advanced on every accepted word in RUN.
  - Index = lfsr[IDX_W-1:0]; if >= CW_W, subtract CW_W once.
- Simultaneous cfg_arm and transfer: the transfer uses the old state and shadows; the new config takes effect from the next cycle.
- DOUBLE with idx_a == idx_b: only one flip is applied.
- Bad index:
  - Any shadow index >= CW_W at injection time: no flip for that index and err_bad_idx is set.
  - If no bit is flipped, out_injected=0 and inj_count does not advance. The FSM still advances.
- out_injected is registered with the word. inj_count increments on the same edge.

Optional Feature:
FI_BURST_EN:
- Defined: adds cfg_burst_len (in, 4) and mode 5 BURST. ARMED flips cfg_burst_len contiguous positions starting at idx_a, truncated at CW_W-1. Length 0 counts as 1.
- Undefined: the port is absent and mode 5 behaves as OFF.

Decomposition:
- Package fi_pkg holds:
  - fi_mode_e and fi_state_e enums.
  - check_w(data_w), idx_w and cw_w functions.
  - pos_to_mask(idx) function returning the {check,data} flip mask.
  - LFSR tap constant.
- Sub-module fi_lfsr: 16-bit, with en, seed and rst_n; outputs the state.

Test Plan:
- SINGLE idx_a=3; words 0xA5/0x00 then 0x3C/0x1F -> first out 0xA4/0x00 with out_injected=1; second unchanged; inj_count=1; state DONE.
- DOUBLE idx_a=0, idx_b=12; word 0x00/0x00 -> out 0x80/0x10, out_injected=1.
- PERIODIC period=3; 9 back-to-back words -> only words 3, 6 and 9 flipped at idx_a; inj_count=3.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> in_ready=0 and out fields stable; release -> every word delivered once, in order.
- SINGLE idx_a=13 -> word unchanged, out_injected=0, err_bad_idx=1, inj_count=0.
- RANDOM period=1 running, rst_n low mid-stream -> all outputs 0, LFSR=16'hACE1; re-arm reproduces the same flip-index sequence.

Source files
------------

// File: rtl/fi_pkg.sv
// Shared types, codeword geometry helpers and LFSR taps for the SEC-DED fault injector.
package fi_pkg;

    localparam int MAX_CW = 72;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_SINGLE   = 3'd1,
        MODE_DOUBLE   = 3'd2,
        MODE_PERIODIC = 3'd3,
        MODE_RANDOM   = 3'd4,
        MODE_BURST    = 3'd5
    } fi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } fi_state_e;

    // Hamming check bits plus the overall-parity bit; scanning downward keeps the smallest fit.
    function automatic int check_w(input int data_w);
        int c;
        c = 8;
        for (int r = 7; r >= 2; r--)
            if ((1 << r) >= data_w + r + 1) c = r + 1;
        return c;
    endfunction

    function automatic int cw_w(input int data_w);
        return data_w + check_w(data_w);
    endfunction

    function automatic int idx_w(input int data_w);
        return $clog2(cw_w(data_w));
    endfunction

    // Bit offset inside the {check,data} vector for codeword position p.
    function automatic int pos_bit(input int p, input int data_w);
        if (p == 0) return data_w + check_w(data_w) - 1;
        if ((p & (p - 1)) == 0) return data_w + $clog2(p);
        return p - $clog2(p + 1) - 1;
    endfunction

    function automatic logic [MAX_CW-1:0] pos_to_mask(input int idx, input int data_w);
        logic [MAX_CW-1:0] m;
        int cw;
        m  = '0;
        cw = cw_w(data_w);
        for (int p = 0; p < MAX_CW; p++)
            if (p < cw && idx == p)
                m = m | ({{(MAX_CW-1){1'b0}}, 1'b1} << pos_bit(p, data_w));
        return m;
    endfunction

    function automatic fi_mode_e decode_mode(input logic [2:0] m, input bit burst_en);
        case (m)
            3'd1:    return MODE_SINGLE;
            3'd2:    return MODE_DOUBLE;
            3'd3:    return MODE_PERIODIC;
            3'd4:    return MODE_RANDOM;
            3'd5:    return burst_en ? MODE_BURST : MODE_OFF;
            default: return MODE_OFF;
        endcase
    endfunction

    function automatic fi_state_e mode_to_state(input fi_mode_e m);
        case (m)
            MODE_SINGLE, MODE_DOUBLE, MODE_BURST: return ST_ARMED;
            MODE_PERIODIC, MODE_RANDOM:           return ST_RUN;
            default:                              return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fi_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); reloads the seed on reset, steps when en is high.
module fi_lfsr
    import fi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= seed;
        else if (en)
            state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/fault_injector.sv
// Stream codeword fault injector with one output register stage.
// FI_BURST_EN adds cfg_burst_len and the BURST mode (otherwise mode 5 acts as OFF).
//
// state | meaning
// IDLE  | pass-through, nothing armed
// ARMED | next accepted word gets the one-shot flip (SINGLE/DOUBLE/BURST)
// RUN   | counting words, flip on every period-th word (PERIODIC/RANDOM)
// DONE  | one-shot spent, pass-through until re-armed
module fault_injector
    import fi_pkg::*;
#(
    parameter int          DATA_W    = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         CHECK_W   = check_w(DATA_W),
    localparam int         CW_W      = cw_w(DATA_W),
    localparam int         IDX_W     = idx_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         cfg_mode,
    input  logic [IDX_W-1:0]   cfg_idx_a,
    input  logic [IDX_W-1:0]   cfg_idx_b,
    input  logic [15:0]        cfg_period,
`ifdef FI_BURST_EN
    input  logic [3:0]         cfg_burst_len,
`endif
    input  logic               cfg_arm,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [CHECK_W-1:0] in_check,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CHECK_W-1:0] out_check,
    output logic               out_injected,
    output logic [15:0]        inj_count,
    output logic               err_bad_idx,
    output logic               busy
);

`ifdef FI_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    fi_state_e          state, state_nx;
    fi_mode_e           sh_mode;
    logic [IDX_W-1:0]   sh_idx_a, sh_idx_b;
    logic [15:0]        sh_period, cnt, cnt_nx, period_m1;
    logic [15:0]        lfsr;
    logic               xfer, lfsr_en, bad, a_bad, b_bad;
    logic [CW_W-1:0]    mask;
    int                 rnd_idx;
`ifdef FI_BURST_EN
    logic [3:0]         sh_burst;
    int                 burst_n;
`endif

    function automatic logic [CW_W-1:0] mask_of(input int idx);
        logic [MAX_CW-1:0] m;
        m = pos_to_mask(idx, DATA_W);
        return m[CW_W-1:0];
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign xfer      = in_valid && in_ready;
    assign busy      = (state == ST_ARMED) || (state == ST_RUN);
    assign period_m1 = (sh_period == 16'd0) ? 16'd0 : sh_period - 16'd1;
    assign a_bad     = int'(sh_idx_a) >= CW_W;
    assign b_bad     = int'(sh_idx_b) >= CW_W;

    fi_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        mask     = '0;
        bad      = 1'b0;
        lfsr_en  = 1'b0;
        rnd_idx  = int'(lfsr[IDX_W-1:0]);
        if (rnd_idx >= CW_W) rnd_idx = rnd_idx - CW_W;
`ifdef FI_BURST_EN
        burst_n  = (sh_burst == 4'd0) ? 1 : int'(sh_burst);
`endif
        case (state)
            ST_ARMED: if (xfer) begin
                case (sh_mode)
                    MODE_SINGLE: begin
                        mask = mask_of(int'(sh_idx_a));
                        bad  = a_bad;
                    end
                    MODE_DOUBLE: begin
                        mask = mask_of(int'(sh_idx_a)) | mask_of(int'(sh_idx_b));
                        bad  = a_bad || b_bad;
                    end
`ifdef FI_BURST_EN
                    // Positions past CW_W-1 map to an empty mask, which truncates the run.
                    MODE_BURST: begin
                        for (int i = 0; i < 16; i++)
                            if (i < burst_n) mask = mask | mask_of(int'(sh_idx_a) + i);
                        bad = a_bad;
                    end
`endif
                    default: ;
                endcase
                state_nx = ST_DONE;
            end
            ST_RUN: if (xfer) begin
                lfsr_en = 1'b1;
                if (cnt == period_m1) begin
                    cnt_nx = '0;
                    if (sh_mode == MODE_RANDOM) begin
                        mask = mask_of(rnd_idx);
                    end else begin
                        mask = mask_of(int'(sh_idx_a));
                        bad  = a_bad;
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: ;
        endcase
        // The word accepted this cycle already used the old config above.
        if (cfg_arm) begin
            state_nx = mode_to_state(decode_mode(cfg_mode, BURST_EN));
            cnt_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode   <= MODE_OFF;
            sh_idx_a  <= '0;
            sh_idx_b  <= '0;
            sh_period <= '0;
`ifdef FI_BURST_EN
            sh_burst  <= '0;
`endif
        end else if (cfg_arm) begin
            sh_mode   <= decode_mode(cfg_mode, BURST_EN);
            sh_idx_a  <= cfg_idx_a;
            sh_idx_b  <= cfg_idx_b;
            sh_period <= cfg_period;
`ifdef FI_BURST_EN
            sh_burst  <= cfg_burst_len;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_check    <= '0;
            out_injected <= 1'b0;
            inj_count    <= '0;
            err_bad_idx  <= 1'b0;
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_data     <= in_data ^ mask[DATA_W-1:0];
            out_check    <= in_check ^ mask[CW_W-1:DATA_W];
            out_injected <= |mask;
            if (|mask && inj_count != 16'hFFFF) inj_count <= inj_count + 16'd1;
            if (bad) err_bad_idx <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fault_injector.sv
// Directed bench for fault_injector (DATA_W=8: 5 check bits, 13 positions).
module tb_fault_injector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] cfg_mode;
    logic [3:0] cfg_idx_a, cfg_idx_b;
    logic [15:0] cfg_period;
`ifdef FI_BURST_EN
    logic [3:0] cfg_burst_len;
`endif
    logic       cfg_arm;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic [4:0] in_check;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [4:0] out_check;
    logic       out_injected;
    logic [15:0] inj_count;
    logic       err_bad_idx, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rnd_d [5];
    logic [4:0] rnd_c [5];

    always #5 clk = ~clk;

    fault_injector #(.DATA_W(8), .LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_mode     (cfg_mode),
        .cfg_idx_a    (cfg_idx_a),
        .cfg_idx_b    (cfg_idx_b),
        .cfg_period   (cfg_period),
`ifdef FI_BURST_EN
        .cfg_burst_len(cfg_burst_len),
`endif
        .cfg_arm      (cfg_arm),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_check     (in_check),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_check    (out_check),
        .out_injected (out_injected),
        .inj_count    (inj_count),
        .err_bad_idx  (err_bad_idx),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b,
                       input logic [15:0] per);
        cfg_mode   = m;
        cfg_idx_a  = a;
        cfg_idx_b  = b;
        cfg_period = per;
        cfg_arm    = 1'b1;
        tick();
        cfg_arm    = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic [4:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_check = c;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic [4:0] c,
                              input logic inj);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".data"},  64'(out_data),  64'(d));
        check({tag, ".check"}, 64'(out_check), 64'(c));
        check({tag, ".inj"},   64'(out_injected), 64'(inj));
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".data"},  64'(out_data), 64'd0);
        check({tag, ".check"}, 64'(out_check), 64'd0);
        check({tag, ".inj"},   64'(out_injected), 64'd0);
        check({tag, ".count"}, 64'(inj_count), 64'd0);
        check({tag, ".err"},   64'(err_bad_idx), 64'd0);
        check({tag, ".busy"},  64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_mode = '0; cfg_idx_a = '0; cfg_idx_b = '0; cfg_period = '0;
`ifdef FI_BURST_EN
        cfg_burst_len = '0;
`endif
        cfg_arm = 1'b0; in_valid = 1'b0; in_data = '0; in_check = '0; out_ready = 1'b1;
        // LFSR from 16'hACE1: indices 1,3,7,15->2,14->1
        rnd_d[0] = 8'h00; rnd_c[0] = 5'h01;
        rnd_d[1] = 8'h01; rnd_c[1] = 5'h00;
        rnd_d[2] = 8'h08; rnd_c[2] = 5'h00;
        rnd_d[3] = 8'h00; rnd_c[3] = 5'h02;
        rnd_d[4] = 8'h00; rnd_c[4] = 5'h01;

        #3;
        expect_reset("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // SINGLE at position 3 -> data[0]
        arm(3'd1, 4'd3, 4'd0, 16'd0);
        check("single.busy_armed", 64'(busy), 64'd1);
        send(8'hA5, 5'h00);
        expect_out("single.w1", 8'hA4, 5'h00, 1'b1);
        check("single.count1", 64'(inj_count), 64'd1);
        send(8'h3C, 5'h1F);
        expect_out("single.w2", 8'h3C, 5'h1F, 1'b0);
        check("single.count2", 64'(inj_count), 64'd1);
        check("single.busy_done", 64'(busy), 64'd0);
        idle();
        check("single.drain", 64'(out_valid), 64'd0);

        // DOUBLE at 0 (overall parity) and 12 (data[7])
        arm(3'd2, 4'd0, 4'd12, 16'd0);
        send(8'h00, 5'h00);
        expect_out("double", 8'h80, 5'h10, 1'b1);
        check("double.count", 64'(inj_count), 64'd2);
        idle();

        // PERIODIC period 3 at position 5 -> data[1]
        arm(3'd3, 4'd5, 4'd0, 16'd3);
        check("periodic.busy", 64'(busy), 64'd1);
        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 5'h00);
            expect_out($sformatf("periodic.w%0d", i),
                       8'(i) ^ ((i % 3 == 0) ? 8'h02 : 8'h00), 5'h00, (i % 3 == 0));
        end
        check("periodic.count", 64'(inj_count), 64'd5);
        idle();

        // Backpressure while PERIODIC keeps counting (counter restarts at 0)
        out_ready = 1'b0;
        send(8'h11, 5'h00);
        expect_out("bp.w1", 8'h11, 5'h00, 1'b0);
        in_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("bp.ready%0d", k), 64'(in_ready), 64'd0);
            expect_out($sformatf("bp.hold%0d", k), 8'h11, 5'h00, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.ready_rel", 64'(in_ready), 64'd1);
        tick();
        expect_out("bp.w2", 8'h22, 5'h00, 1'b0);
        send(8'h33, 5'h00);
        expect_out("bp.w3", 8'h31, 5'h00, 1'b1);
        idle();
        check("bp.drain", 64'(out_valid), 64'd0);
        check("bp.count", 64'(inj_count), 64'd6);

        // SINGLE at out-of-range position 13
        arm(3'd1, 4'd13, 4'd0, 16'd0);
        send(8'h55, 5'h0A);
        expect_out("badidx", 8'h55, 5'h0A, 1'b0);
        check("badidx.err", 64'(err_bad_idx), 64'd1);
        check("badidx.count", 64'(inj_count), 64'd6);
        check("badidx.busy", 64'(busy), 64'd0);
        idle();

        // Arm coincident with a transfer: that word uses DONE, the next gets check[2]
        in_valid = 1'b1; in_data = 8'h77; in_check = 5'h00;
        arm(3'd1, 4'd4, 4'd0, 16'd0);
        expect_out("armx.w1", 8'h77, 5'h00, 1'b0);
        check("armx.busy", 64'(busy), 64'd1);
        send(8'h77, 5'h00);
        expect_out("armx.w2", 8'h77, 5'h04, 1'b1);
        check("armx.count", 64'(inj_count), 64'd7);
        idle();

        // RANDOM running, then asynchronous reset mid-stream
        arm(3'd4, 4'd0, 4'd0, 16'd1);
        send(8'h00, 5'h00);
        check("rnd_pre.inj1", 64'(out_injected), 64'd1);
        send(8'h00, 5'h00);
        check("rnd_pre.inj2", 64'(out_injected), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        expect_reset("midreset");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Two passes from the seed must give the same index sequence; period 0 acts as 1
        for (int pass = 0; pass < 2; pass++) begin
            arm(3'd4, 4'd0, 4'd0, 16'd0);
            for (int j = 0; j < 5; j++) begin
                send(8'h00, 5'h00);
                expect_out($sformatf("rnd%0d.w%0d", pass, j), rnd_d[j], rnd_c[j], 1'b1);
            end
            check($sformatf("rnd%0d.count", pass), 64'(inj_count), 64'd5);
            idle();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
